// File: rtl/div_pkg.sv
// Shared constants for the sequential non-restoring divider: FSM encoding and
// the default operand width.
package div_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/addsub_row.sv
// Ripple row of controlled adder/subtractor cells: sum = a + (b ^ {N{sub}}) + sub.
// With sub=1 this is a - b in two's complement.
module addsub_row #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = sub;

    for (genvar i = 0; i < N; i++) begin : g_cell
        logic bx;
        assign bx         = b[i] ^ sub;
        assign sum[i]     = a[i] ^ bx ^ carry[i];
        assign carry[i+1] = (a[i] & bx) | (a[i] & carry[i]) | (bx & carry[i]);
    end

    assign cout = carry[N];

endmodule

// File: rtl/seq_nonrestoring_divider.sv
// Unsigned sequential divider, one quotient bit per cycle (non-restoring),
// followed by a single remainder-correction cycle.
module seq_nonrestoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;

    logic [WIDTH:0]   op_a;
    logic [WIDTH:0]   op_b;
    logic             op_sub;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_fix;
    logic             unused_cout;

    // One adder row serves both the iteration step and the final correction.
    always_comb begin
        op_b = {1'b0, d_r};
        if (state == S_FIX) begin
            op_a   = rem_r;
            op_sub = 1'b0;
        end else begin
            op_a   = {rem_r[WIDTH-1:0], q_r[WIDTH-1]};
            op_sub = ~rem_r[WIDTH];
        end
    end

    addsub_row #(.N(WIDTH + 1)) u_row (
        .a    (op_a),
        .b    (op_b),
        .sub  (op_sub),
        .sum  (sum),
        .cout (unused_cout)
    );

    assign rem_fix = rem_r[WIDTH] ? sum : rem_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            d_r         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        d_r         <= divisor;
                        q_r         <= dividend;
                        rem_r       <= '0;
                        cnt         <= CW'(WIDTH);
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_r <= sum;
                    q_r   <= {q_r[WIDTH-2:0], ~sum[WIDTH]};
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    rem_r     <= rem_fix;
                    quotient  <= q_r;
                    remainder <= rem_fix[WIDTH-1:0];
                    state     <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Directed bench for seq_nonrestoring_divider at WIDTH=8 plus a randomized
// sweep on a WIDTH=16 instance checked against integer division.
module tb_seq_nonrestoring_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 1'b0;
    logic [7:0] dividend = '0, divisor = '0;
    logic [7:0] quotient, remainder;
    logic       busy, done, div_by_zero;

    logic        start16 = 1'b0;
    logic [15:0] dividend16 = '0, divisor16 = '0;
    logic [15:0] quotient16, remainder16;
    logic        busy16, done16, div_by_zero16;

    int n_cmp = 0;
    int n_bad = 0;

    seq_nonrestoring_divider #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    seq_nonrestoring_divider #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .dividend(dividend16), .divisor(divisor16),
        .busy(busy16), .done(done16), .quotient(quotient16), .remainder(remainder16),
        .div_by_zero(div_by_zero16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one start, wait for done, check latency/results, then check the pulse ends.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input logic [7:0] exp_q, input logic [7:0] exp_r,
                        input logic exp_dz);
        int lat;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy"}, busy, 1);
        chk({tag, " quotient"}, quotient, exp_q);
        chk({tag, " remainder"}, remainder, exp_r);
        chk({tag, " div_by_zero"}, div_by_zero, exp_dz);
        @(negedge clk);
        chk({tag, " done pulse"}, done, 0);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b);
        int lat;
        @(negedge clk);
        dividend16 = a; divisor16 = b; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; lat = 1;
        while (!done16 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("w16 latency", lat, 18);
        chk("w16 quotient", quotient16, 32'(a / b));
        chk("w16 remainder", remainder16, 32'(a % b));
    endtask

    initial begin
        int lat;
        int ndone;

        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset div_by_zero", div_by_zero, 0);
        rst = 1'b0;

        run8("100/7", 8'd100, 8'd7, 10, 8'd14, 8'd2, 1'b0);
        run8("255/1", 8'd255, 8'd1, 10, 8'd255, 8'd0, 1'b0);
        run8("5/9", 8'd5, 8'd9, 10, 8'd0, 8'd5, 1'b0);
        run8("255/255", 8'd255, 8'd255, 10, 8'd1, 8'd0, 1'b0);
        run8("37/0", 8'd37, 8'd0, 1, 8'hFF, 8'd37, 1'b1);
        chk("dbz hold", div_by_zero, 1);
        chk("quotient hold", quotient, 255);
        run8("8/2", 8'd8, 8'd2, 10, 8'd4, 8'd0, 1'b0);
        run8("128/129", 8'd128, 8'd129, 10, 8'd0, 8'd128, 1'b0);
        run8("254/127", 8'd254, 8'd127, 10, 8'd2, 8'd0, 1'b0);

        // start held high with operands changing while busy
        @(negedge clk);
        dividend = 8'd200; divisor = 8'd3; start = 1'b1;
        @(negedge clk);
        dividend = 8'd9; divisor = 8'd9; lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("held latency", lat, 10);
        chk("held quotient", quotient, 66);
        chk("held remainder", remainder, 2);
        start = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("held extra done", ndone, 0);
        chk("held quotient hold", quotient, 66);

        // reset during RUN cycle 4
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort quotient", quotient, 0);
        chk("abort remainder", remainder, 0);
        chk("abort div_by_zero", div_by_zero, 0);
        rst = 1'b0;
        dividend = 8'd50; divisor = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("after abort latency", lat, 10);
        chk("after abort quotient", quotient, 10);
        chk("after abort remainder", remainder, 0);

        // reset wins over start in the same cycle
        @(negedge clk);
        rst = 1'b1; dividend = 8'd5; divisor = 8'd1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst priority busy", busy, 0);
        @(negedge clk);
        chk("rst priority idle", busy, 0);
        chk("rst priority quotient", quotient, 0);

        for (int i = 0; i < 150; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            run8("sweep8", a, b, 10, a / b, a % b, 1'b0);
        end

        for (int i = 0; i < 200; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom_range(0, 65535));
            b = (i % 2 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
            run16(a, b);
        end
        run16(16'hFFFF, 16'd1);
        run16(16'hFFFF, 16'hFFFF);
        run16(16'd3, 16'h8001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_nonrestoring_divider.md
SEQ_NONRESTORING_DIVIDER -- requirements
Module: seq_nonrestoring_divider

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand width; legal range is 4..32.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled only while idle.
REQ-005 dividend  input  WIDTH  unsigned dividend, captured on accepted start.
REQ-006 divisor  input  WIDTH  unsigned divisor, captured on accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start through the done cycle, inclusive.
REQ-008 done  output  1  one-cycle pulse marking quotient/remainder valid.
REQ-009 quotient  output  WIDTH  unsigned quotient.
REQ-010 remainder  output  WIDTH  unsigned remainder.
REQ-011 div_by_zero  output  1  set with done when the captured divisor is 0.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, FIX and DONE.
REQ-013 IDLE with start=1 SHALL capture the operands, clear the partial remainder R (WIDTH+1 bits, signed), load Q=dividend and count=WIDTH, then go to RUN; if divisor=0 it SHALL go to DONE instead.
REQ-014 In IDLE with start=0, and in every non-IDLE state, start SHALL be ignored and captured operands SHALL NOT change.
REQ-015 Each RUN cycle SHALL shift {R,Q} left one bit, add D when R<0 or subtract D when R>=0, set Q[0]=~sign(new R), and decrement count.
REQ-016 RUN SHALL last exactly WIDTH cycles; after the count reaches 0 the FSM SHALL go to FIX.
REQ-017 FIX SHALL add D to R when R<0 and leave R unchanged otherwise, then go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-019 quotient/remainder SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-020 For a nonzero divisor, an accepted start at edge 0 SHALL produce done high in cycle WIDTH+2.
REQ-021 For a divisor of 0, done SHALL be high in cycle 1, with quotient = all ones, remainder = dividend and div_by_zero = 1.
REQ-022 div_by_zero SHALL be cleared on the next accepted start and SHALL otherwise hold.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every nonzero divisor.
REQ-024 Overflow SHALL be impossible, because quotient width equals dividend width.

Reset
REQ-025 rst=1 SHALL force IDLE with busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, and count/R/Q/D cleared.
REQ-026 rst asserted mid-operation SHALL abort the division with no done pulse, and the block SHALL accept start on the first cycle after rst deasserts.
REQ-027 rst SHALL take priority over start in the same cycle.

Structure
REQ-028 A shared package div_pkg SHALL hold the state encoding constants and the default WIDTH.
REQ-029 The add/subtract datapath SHALL be one sub-module, addsub_row: a WIDTH+1-bit row of controlled adder/subtractor cells with inputs a, b, sub and outputs sum, cout, where sub XORs b and feeds the carry-in.
REQ-030 The control FSM, counter and registers SHALL live in seq_nonrestoring_divider.

Verification
REQ-031 WIDTH=8, start with 100/7 at cycle 0 -> done at cycle 10, quotient=14, remainder=2, div_by_zero=0.
REQ-032 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5; 255/255 -> quotient=1, remainder=0.
REQ-033 37/0 -> done at cycle 1, quotient=0xFF, remainder=37, div_by_zero=1; a following 8/2 -> div_by_zero=0, quotient=4.
REQ-034 Start 200/3 with start held high and operands changed to 9/9 during busy -> one done only, quotient=66, remainder=2.
REQ-035 rst pulsed in RUN cycle 4 of 100/7 -> no done, all outputs 0; start 50/5 on the next cycle -> quotient=10, remainder=0.
REQ-036 A random sweep at WIDTH=4 and WIDTH=16 (10k operand pairs) -> every result satisfies REQ-023 and REQ-020 latency.
